spi_frame_master: RTL and testbench

//  - SPI initiator (mode 0: CPOL=0, CPHA=0) for the FPGA's frame-loading SPI link; drives sck/sdi/load, samples sdo.
//  - Shifts one FRAME_W-bit frame out MSB first, framed by load; captures FRAME_W bits of sdo full-duplex.
//  - Used FPGA-to-FPGA and as the bench-side driver for the LED-string receiver (432-bit frame).

---
 rtl/spi_master_pkg.sv | 26 ++
 rtl/spi_frame_master_if.sv | 29 ++
 rtl/spi_sck_tick.sv | 42 ++++
 rtl/spi_frame_master.sv | 173 +++++++++++++++++
 tb/tb_spi_frame_master.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and default parameters for the SPI frame master.
//   state_t      : frame sequencer states
//   DEF_*        : default frame width and timing (432-bit LED-string frame)
//   max3()       : helper used to size the shared phase timer
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD
  } state_t;

  localparam int DEF_FRAME_W   = 432;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_HOLD_CYC  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_frame_master_if.sv
// Bundle of the frame-request handshake and the SPI wires.
//   start/tx_data      : frame request and payload (to the master)
//   busy/done/rx_data  : frame status and captured data (from the master)
//   sck/sdi/load       : SPI outputs driven by the master
//   sdo                : SPI data returned by the responder
// master modport: the SPI initiator. slave modport: the user of the initiator.
interface spi_frame_master_if #(
  parameter int FRAME_W = spi_master_pkg::DEF_FRAME_W
);
  logic               start;
  logic [FRAME_W-1:0] tx_data;
  logic               busy;
  logic               done;
  logic [FRAME_W-1:0] rx_data;
  logic               sck;
  logic               sdi;
  logic               sdo;
  logic               load;

  modport master (
    input  start, tx_data, sdo,
    output busy, done, rx_data, sck, sdi, load
  );

  modport slave (
    output start, tx_data, sdo,
    input  busy, done, rx_data, sck, sdi, load
  );
endinterface

// File: rtl/spi_sck_tick.sv
// Reloadable down-counter that times every phase of a frame.
//   clk, reset  : clock and asynchronous active-high reset
//   reload      : load a new phase length this cycle
//   reload_val  : phase length N in clk cycles (N >= 1)
//   tick        : high in the last cycle of an N-cycle phase
// The counter parks at zero, so tick stays high until the next reload;
// the sequencer reloads on every state change and only looks at tick
// inside a timed state.
module spi_sck_tick #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reload,
  input  logic [W-1:0] reload_val,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      // The reload cycle itself counts as the first cycle of the phase.
      cnt_d = reload_val - W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame initiator. Sends one FRAME_W-bit frame MSB first under
// load, capturing sdo full-duplex on every sck rise.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : spi_frame_master_if.master
//                start/tx_data in, busy/done/rx_data out,
//                sck/sdi/load out, sdo in
// All outputs come straight from flops.
module spi_frame_master
  import spi_master_pkg::*;
#(
  parameter int FRAME_W   = DEF_FRAME_W,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_frame_master_if.master    bus
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int TMR_W = $clog2(max3(CLK_DIV, SETUP_CYC, HOLD_CYC) + 1);

  state_t             state_q, state_d;

  logic               tick;
  logic               reload;
  logic [TMR_W-1:0]   reload_val;

  logic               accept;
  logic               last_bit;
  logic               rise;
  logic               fall;

  logic [FRAME_W-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               sck_q, sck_d;
  logic               sdi_q, sdi_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // busy_q is already low during the done cycle, so a start held high
  // launches the next frame with load low for exactly one cycle.
  assign accept   = (state_q == IDLE) && bus.start && !busy_q;
  // bit_cnt_q counts sck rises already issued in this frame.
  assign last_bit = (bit_cnt_q == CNT_W'(FRAME_W));

  spi_sck_tick #(
    .W (TMR_W)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .reload_val (reload_val),
    .tick       (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = SETUP;
      SETUP:    if (tick)   state_d = SHIFT_HI;
      SHIFT_HI: if (tick)   state_d = SHIFT_LO;
      SHIFT_LO: if (tick)   state_d = last_bit ? HOLD : SHIFT_HI;
      HOLD:     if (tick)   state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Output / datapath next values. sck edges are derived from the state
  // transition so the registered sck changes on the same edge that
  // samples sdo (rise) or advances sdi (fall).
  always_comb begin
    rise       = (state_d == SHIFT_HI) && (state_q != SHIFT_HI);
    fall       = (state_q == SHIFT_HI) && (state_d == SHIFT_LO);
    reload     = (state_d != state_q);
    reload_val = TMR_W'(1);
    unique case (state_d)
      SETUP:    reload_val = TMR_W'(SETUP_CYC);
      SHIFT_HI: reload_val = TMR_W'(CLK_DIV);
      SHIFT_LO: reload_val = TMR_W'(CLK_DIV);
      HOLD:     reload_val = TMR_W'(HOLD_CYC);
      default:  reload_val = TMR_W'(1);
    endcase

    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    load_d    = load_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (accept) begin
      // MSB goes straight to sdi; the shifter holds the remaining bits.
      sdi_d     = bus.tx_data[FRAME_W-1];
      tx_sh_d   = {bus.tx_data[FRAME_W-2:0], 1'b0};
      bit_cnt_d = '0;
      load_d    = 1'b1;
      busy_d    = 1'b1;
    end

    if (rise) begin
      sck_d     = 1'b1;
      rx_sh_d   = {rx_sh_q[FRAME_W-2:0], bus.sdo};
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    if (fall) begin
      sck_d   = 1'b0;
      sdi_d   = tx_sh_q[FRAME_W-1];
      tx_sh_d = {tx_sh_q[FRAME_W-2:0], 1'b0};
    end

    if ((state_q == SHIFT_LO) && (state_d == HOLD)) begin
      sdi_d = 1'b0;
    end

    if ((state_q == HOLD) && (state_d == IDLE)) begin
      load_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      rx_data_d = rx_sh_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sck     = sck_q;
  assign bus.sdi     = sdi_q;
  assign bus.load    = load_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: a 432-bit default instance and an 8-bit
// CLK_DIV=1 instance, checked against frame-level expectations.
module tb_spi_frame_master;

  localparam int BW   = 432;
  localparam int SW   = 8;
  localparam int BDIV = 4;
  localparam int SDIV = 1;
  localparam int SU   = 2;
  localparam int HO   = 2;

  typedef logic [431:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_frame_master_if #(.FRAME_W(BW)) big_if ();
  spi_frame_master_if #(.FRAME_W(SW)) small_if ();

  spi_frame_master #(.FRAME_W(BW), .CLK_DIV(BDIV), .SETUP_CYC(SU), .HOLD_CYC(HO)) dut_big (
    .clk   (clk),
    .reset (reset),
    .bus   (big_if)
  );

  spi_frame_master #(.FRAME_W(SW), .CLK_DIV(SDIV), .SETUP_CYC(SU), .HOLD_CYC(HO)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (small_if)
  );

  int   total = 0;
  int   bad = 0;

  // Responder model: sdo presents bit (fw-1-k) of sdo_vec before the k-th rise.
  logic loopback = 1'b0;
  vec_t sdo_vec0 = '0;
  vec_t sdo_vec1 = '0;
  int   base0 = 0;
  int   base1 = 0;

  // Monitor-owned observations.
  int   rises0 = 0, rises1 = 0;
  int   load_bad0 = 0, load_bad1 = 0;
  int   done_cnt0 = 0, done_cnt1 = 0;
  vec_t sdi_vec0 = '0, sdi_vec1 = '0;
  logic sck_prev0 = 1'b0, sck_prev1 = 1'b0;

  function automatic logic sdo_pick(input vec_t v, input int idx, input int fw);
    if (idx >= 0 && idx < fw) return v[fw-1-idx];
    return 1'b0;
  endfunction

  assign big_if.sdo   = loopback ? big_if.sdi : sdo_pick(sdo_vec0, rises0 - base0, BW);
  assign small_if.sdo = sdo_pick(sdo_vec1, rises1 - base1, SW);

  always begin
    @(posedge clk);
    #1;
    if (big_if.sck && !sck_prev0) begin
      sdi_vec0 = {sdi_vec0[430:0], big_if.sdi};
      if (!big_if.load) load_bad0++;
      rises0++;
    end
    if (big_if.done) done_cnt0++;
    sck_prev0 = big_if.sck;
    if (small_if.sck && !sck_prev1) begin
      sdi_vec1 = {sdi_vec1[430:0], small_if.sdi};
      if (!small_if.load) load_bad1++;
      rises1++;
    end
    if (small_if.done) done_cnt1++;
    sck_prev1 = small_if.sck;
  end

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v = '0;
    for (int i = 0; i < 14; i++) v = {v[399:0], $urandom()};
    return v;
  endfunction

  function automatic vec_t mask(input vec_t v, input int fw);
    vec_t m;
    m = (vec_t'(1) << fw) - vec_t'(1);
    return v & m;
  endfunction

  // Start sample edge to done-high cycle, counted as cycles.
  function automatic int exp_lat(input int fw, input int div);
    return 1 + SU + 2 * div * fw + HO;
  endfunction

  task automatic start_frame(input int sel, input vec_t tx, input vec_t sdo_v);
    @(negedge clk);
    if (sel == 0) begin
      sdo_vec0 = sdo_v;
      base0 = rises0;
      big_if.tx_data = tx;
      big_if.start = 1'b1;
    end else begin
      sdo_vec1 = sdo_v;
      base1 = rises1;
      small_if.tx_data = tx[7:0];
      small_if.start = 1'b1;
    end
  endtask

  task automatic wait_done(input int sel, input int budget, inout int lat);
    while (lat < budget) begin
      @(negedge clk);
      lat++;
      if (sel == 0) big_if.start = 1'b0;
      else small_if.start = 1'b0;
      if ((sel == 0) ? big_if.done : small_if.done) return;
    end
  endtask

  task automatic wait_rises_big(input int n, input int budget, inout int lat);
    while ((rises0 - base0) < n && lat < budget) begin
      @(negedge clk);
      lat++;
      big_if.start = 1'b0;
    end
  endtask

  task automatic check_frame(input int sel, input string tag, input vec_t tx, input vec_t rx, input int lat);
    int fw;
    int div;
    fw  = (sel == 0) ? BW : SW;
    div = (sel == 0) ? BDIV : SDIV;
    chk($sformatf("%s_latency", tag), vec_t'(lat), vec_t'(exp_lat(fw, div)));
    chk($sformatf("%s_rises", tag), vec_t'((sel == 0) ? rises0 - base0 : rises1 - base1), vec_t'(fw));
    chk($sformatf("%s_sdi_seq", tag), mask((sel == 0) ? sdi_vec0 : sdi_vec1, fw), mask(tx, fw));
    chk($sformatf("%s_load_at_rise", tag), vec_t'((sel == 0) ? load_bad0 : load_bad1), vec_t'(0));
    chk($sformatf("%s_rx_data", tag), (sel == 0) ? big_if.rx_data : vec_t'(small_if.rx_data), mask(rx, fw));
    chk($sformatf("%s_busy_at_done", tag), vec_t'((sel == 0) ? big_if.busy : small_if.busy), vec_t'(0));
    $display("frame %s: latency=%0d rx=%0h", tag, lat, mask(rx, fw));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t, s, t2;
    int   lat;
    int   cyc;
    int   low_run;
    int   dc;
    int   dq[$];

    big_if.start = 1'b0;
    big_if.tx_data = '0;
    small_if.start = 1'b0;
    small_if.tx_data = '0;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sck", vec_t'(big_if.sck), vec_t'(0));
    chk("rst_sdi", vec_t'(big_if.sdi), vec_t'(0));
    chk("rst_load", vec_t'(big_if.load), vec_t'(0));
    chk("rst_busy", vec_t'(big_if.busy), vec_t'(0));
    chk("rst_done", vec_t'(big_if.done), vec_t'(0));
    chk("rst_rx_data", big_if.rx_data, vec_t'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Alternating pattern, sdo held low.
    t = {216{2'b10}};
    start_frame(0, t, '0);
    lat = 0;
    wait_done(0, 4000, lat);
    check_frame(0, "alt10", t, '0, lat);

    // Random payload and random responder data.
    for (int k = 0; k < 2; k++) begin
      t = rand_vec();
      s = rand_vec();
      start_frame(0, t, s);
      lat = 0;
      wait_done(0, 4000, lat);
      check_frame(0, $sformatf("rand%0d", k), t, s, lat);
    end

    // Loopback: rx must equal tx.
    loopback = 1'b1;
    t = {54{8'hA5}};
    start_frame(0, t, '0);
    lat = 0;
    wait_done(0, 4000, lat);
    check_frame(0, "loopA5", t, t, lat);
    loopback = 1'b0;

    // Small frame, CLK_DIV=1.
    t = vec_t'(8'hC3);
    start_frame(1, t, '1);
    lat = 0;
    wait_done(1, 100, lat);
    check_frame(1, "smallC3", t, '1, lat);
    for (int k = 0; k < 4; k++) begin
      t = rand_vec();
      s = rand_vec();
      start_frame(1, t, s);
      lat = 0;
      wait_done(1, 100, lat);
      check_frame(1, $sformatf("small_rand%0d", k), t, s, lat);
    end

    // start held high: back-to-back frames, load low for one cycle between.
    t = rand_vec();
    start_frame(0, t, '0);
    cyc = 0;
    low_run = 0;
    while (cyc < 7500 && dq.size() < 2) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5000) big_if.start = 1'b0;
      if (big_if.done) dq.push_back(cyc);
      if (dq.size() == 1 && !big_if.load) low_run++;
    end
    big_if.start = 1'b0;
    chk("held_done_count", vec_t'(dq.size()), vec_t'(2));
    chk("held_first_done", vec_t'((dq.size() > 0) ? dq[0] : -1), vec_t'(exp_lat(BW, BDIV)));
    chk("held_second_done", vec_t'((dq.size() > 1) ? dq[1] : -1), vec_t'(2 * exp_lat(BW, BDIV)));
    chk("held_load_low_run", vec_t'(low_run), vec_t'(1));
    $display("held start: done cycles=%0d,%0d load_low=%0d",
             (dq.size() > 0) ? dq[0] : -1, (dq.size() > 1) ? dq[1] : -1, low_run);

    // Reset mid-frame after the 100th sck rise.
    t = rand_vec();
    s = rand_vec();
    start_frame(0, t, s);
    lat = 0;
    wait_rises_big(100, 2000, lat);
    chk("abort_rises_reached", vec_t'(rises0 - base0), vec_t'(100));
    dc = done_cnt0;
    #2;
    reset = 1'b1;
    #1;
    chk("abort_sck", vec_t'(big_if.sck), vec_t'(0));
    chk("abort_load", vec_t'(big_if.load), vec_t'(0));
    chk("abort_sdi", vec_t'(big_if.sdi), vec_t'(0));
    chk("abort_busy", vec_t'(big_if.busy), vec_t'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", vec_t'(done_cnt0 - dc), vec_t'(0));
    chk("abort_rx_cleared", big_if.rx_data, vec_t'(0));
    $display("abort after 100 rises: done pulses=%0d", done_cnt0 - dc);
    t = rand_vec();
    s = rand_vec();
    start_frame(0, t, s);
    lat = 0;
    wait_done(0, 4000, lat);
    check_frame(0, "after_abort", t, s, lat);

    // start and tx_data change while busy at bit 200.
    t = rand_vec();
    s = rand_vec();
    start_frame(0, t, s);
    lat = 0;
    wait_rises_big(200, 3000, lat);
    t2 = rand_vec();
    big_if.tx_data = t2;
    big_if.start = 1'b1;
    dc = done_cnt0;
    wait_done(0, 4000, lat);
    check_frame(0, "busy_start", t, s, lat);
    repeat (20) @(negedge clk);
    chk("busy_start_idle", vec_t'(big_if.busy), vec_t'(0));
    chk("busy_start_one_done", vec_t'(done_cnt0 - dc), vec_t'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
